// File: rtl/wb_result_drain.sv
// Result-bus drain: queues execute result bundles and retires them slot by slot
// onto the GPR, segment and memory write ports, back-pressuring execute when full.
module wb_result_drain #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DATA_W-1:0]   res_data,
    input  logic [4*ADDR_W-1:0]   res_dest,
    input  logic [3:0]            res_wb,
    input  logic [3:0]            res_is_reg,
    input  logic [3:0]            res_is_seg,
    input  logic [3:0]            res_is_mem,
    input  logic [1:0]            ressize,
    input  logic                  flush,
    output logic                  reg_we,
    output logic                  seg_we,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [1:0]            wr_size,
    output logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  retire
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_REG  = 2'd1;
    localparam logic [1:0] K_SEG  = 2'd2;
    localparam logic [1:0] K_MEM  = 2'd3;

    // Target is resolved at push time so the drain FSM only sees one kind per slot.
    typedef struct packed {
        logic [3:0][DATA_W-1:0] data;
        logic [3:0][ADDR_W-1:0] dest;
        logic [3:0][1:0]        kind;
        logic [1:0]             size;
    } entry_t;

    typedef enum logic [2:0] {IDLE, SCAN, ISSUE, STROBE, MEMW} state_t;

    entry_t             fifo_q [DEPTH];
    entry_t             push_entry;
    entry_t             head;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    state_t             state_q, state_d;
    logic [2:0]         slot_q, slot_d;
    logic               push, pop;
    logic               found;
    logic [1:0]         found_idx;
    logic               in_ready_d, reg_we_d, seg_we_d, mem_req_d, retire_d;
    logic [ADDR_W-1:0]  wr_addr_d;
    logic [DATA_W-1:0]  wr_data_d;
    logic [1:0]         wr_size_d;

    assign head = fifo_q[rd_ptr_q];
    assign push = in_valid && in_ready && !flush;

    always_comb begin
        push_entry = '0;
        for (int k = 0; k < 4; k++) begin
            push_entry.data[k] = res_data[k*DATA_W +: DATA_W];
            push_entry.dest[k] = res_dest[k*ADDR_W +: ADDR_W];
            if (!res_wb[k])         push_entry.kind[k] = K_NONE;
            else if (res_is_reg[k]) push_entry.kind[k] = K_REG;
            else if (res_is_seg[k]) push_entry.kind[k] = K_SEG;
            else if (res_is_mem[k]) push_entry.kind[k] = K_MEM;
            else                    push_entry.kind[k] = K_NONE;
        end
        push_entry.size = ressize;
    end

    // Lowest active slot at or after the current scan position.
    always_comb begin
        found     = 1'b0;
        found_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (3'(k) >= slot_q && head.kind[k] != K_NONE) begin
                found     = 1'b1;
                found_idx = 2'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        pop       = 1'b0;
        reg_we_d  = 1'b0;
        seg_we_d  = 1'b0;
        mem_req_d = 1'b0;
        retire_d  = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        wr_size_d = wr_size;
        case (state_q)
            IDLE: begin
                if (count_q != '0 && !flush) begin
                    state_d = SCAN;
                    slot_d  = 3'd0;
                end
            end
            SCAN: begin
                if (found) begin
                    slot_d  = {1'b0, found_idx};
                    state_d = ISSUE;
                end else begin
                    retire_d = 1'b1;
                    pop      = 1'b1;
                    state_d  = IDLE;
                end
            end
            ISSUE: begin
                wr_addr_d = head.dest[slot_q[1:0]];
                wr_data_d = head.data[slot_q[1:0]];
                wr_size_d = head.size;
                case (head.kind[slot_q[1:0]])
                    K_REG: begin
                        reg_we_d = 1'b1;
                        state_d  = STROBE;
                    end
                    K_SEG: begin
                        seg_we_d = 1'b1;
                        state_d  = STROBE;
                    end
                    default: begin
                        mem_req_d = 1'b1;
                        state_d   = MEMW;
                    end
                endcase
            end
            STROBE: begin
                slot_d  = slot_q + 3'd1;
                state_d = SCAN;
            end
            MEMW: begin
                if (mem_ack) begin
                    slot_d  = slot_q + 3'd1;
                    state_d = SCAN;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush keeps only the entry the FSM is working on; a push in that cycle is dropped.
    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (flush) begin
            if (state_q != IDLE && !pop) begin
                count_d  = CNT_W'(1);
                wr_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                count_d  = '0;
                wr_ptr_d = rd_ptr_d;
            end
        end
        in_ready_d = (count_d != CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            in_ready <= 1'b1;
            reg_we   <= 1'b0;
            seg_we   <= 1'b0;
            mem_req  <= 1'b0;
            retire   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_size  <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            in_ready <= in_ready_d;
            reg_we   <= reg_we_d;
            seg_we   <= seg_we_d;
            mem_req  <= mem_req_d;
            retire   <= retire_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
            wr_size  <= wr_size_d;
        end
    end

endmodule
